// File: rtl/instr_mem_pkg.sv
// Shared constants and helpers for the pipelined instruction memory.
// Latency: none (declarations only).
// Backpressure: not applicable.
package instr_mem_pkg;

   // Instruction returned for errored fetches unless overridden (sll $0,$0,0).
   localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;

   // Fetch error causes; only their non-zero-ness leaves the block as rsp_err,
   // the encoding is kept so a debug probe can tell the two apart.
   localparam logic [1:0] ERR_NONE     = 2'd0;
   localparam logic [1:0] ERR_MISALIGN = 2'd1;
   localparam logic [1:0] ERR_RANGE    = 2'd2;

   // Width of a word index into a memory of 'depth' words (never below 1).
   function automatic int word_idx_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/resp_fifo2.sv
// Two-entry synchronous FIFO holding {err, instr} fetch responses.
// Latency: a pushed entry is visible at o_dat on the cycle after the push.
// Backpressure: push is ignored when full unless a pop happens in the same cycle.
module resp_fifo2 #(
   parameter int W = 33
) (
   input  logic         i_clk,
   input  logic         i_reset,
   input  logic         i_push,
   input  logic [W-1:0] i_dat,
   input  logic         i_pop,
   output logic [W-1:0] o_dat,
   output logic [1:0]   o_count,
   output logic         o_full,
   output logic         o_empty
);

   logic [W-1:0] r_slot [2];
   logic         r_wr_ptr;
   logic         r_rd_ptr;
   logic [1:0]   r_count;
   logic         w_do_push;
   logic         w_do_pop;

   assign o_full    = (r_count == 2'd2);
   assign o_empty   = (r_count == 2'd0);
   assign o_count   = r_count;
   assign o_dat     = r_slot[r_rd_ptr];

   // A pop frees a slot in the same cycle, so a full FIFO can still take a push
   // while it is being drained; the count then stays at two.
   assign w_do_pop  = i_pop && !o_empty;
   assign w_do_push = i_push && (!o_full || w_do_pop);

   // Pointer and occupancy bookkeeping; cleared by reset.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= !r_wr_ptr;
         end
         if (w_do_pop) begin
            r_rd_ptr <= !r_rd_ptr;
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Entry storage; contents are don't-care while the slot is empty.
   always_ff @(posedge i_clk) begin
      if (w_do_push) begin
         r_slot[r_wr_ptr] <= i_dat;
      end
   end

endmodule

// File: rtl/instr_mem_pipe.sv
// Synchronous-read instruction memory with valid/ready fetch and a program-load port.
// Latency: response 1+OUT_REG cycles after request acceptance.
// Backpressure: at most two fetches outstanding (queued + in flight); req_ready drops at the limit.
module instr_mem_pipe
   import instr_mem_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter int                DATA_W   = 32,
   parameter int                DEPTH    = 256,
   parameter int                OUT_REG  = 0,
   parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_DEFAULT)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         req_valid,
   output logic                         req_ready,
   input  logic [ADDR_W-1:0]            req_addr,
   output logic                         rsp_valid,
   input  logic                         rsp_ready,
   output logic [DATA_W-1:0]            rsp_instr,
   output logic                         rsp_err,
   input  logic                         load_en,
   input  logic [word_idx_w(DEPTH)-1:0] load_addr,
   input  logic [DATA_W-1:0]            load_data
);

   localparam int IDX_W = word_idx_w(DEPTH);
   localparam int ENT_W = DATA_W + 1;

   // Instruction storage; deliberately not touched by reset so a loaded
   // program survives a core reset.
   logic [DATA_W-1:0] r_mem [DEPTH];

   logic              w_accept;
   logic              w_misalign;
   logic              w_range;
   logic [1:0]        w_err_cause;
   logic              w_err;
   logic [IDX_W-1:0]  w_idx;
   logic [DATA_W-1:0] w_rd_dat;

   logic              w_push;
   logic [ENT_W-1:0]  w_push_dat;
   logic              w_inflight;
   logic              w_pop;
   logic [ENT_W-1:0]  w_head;
   logic [1:0]        w_count;
   logic              w_full;
   logic              w_empty;
   logic              w_credit_ok;

   // ------------------------------------------------------------------
   // Address decode and error classification at acceptance
   // ------------------------------------------------------------------
   assign w_idx      = req_addr[2 +: IDX_W];
   assign w_misalign = |req_addr[1:0];

   // DEPTH is a power of two, so "word address >= DEPTH" is simply any
   // address bit set above the word index.
   generate
      if (ADDR_W > 2 + IDX_W) begin : g_range
         assign w_range = |req_addr[ADDR_W-1:2+IDX_W];
      end else begin : g_no_range
         assign w_range = 1'b0;
      end
   endgenerate

   // Pick the error cause; misalignment is reported in preference to range.
   always_comb begin
      w_err_cause = ERR_NONE;
      if (w_misalign) begin
         w_err_cause = ERR_MISALIGN;
      end else if (w_range) begin
         w_err_cause = ERR_RANGE;
      end
   end

   assign w_err    = (w_err_cause != ERR_NONE);

   // Errored fetches never look at the array and carry the NOP word instead.
   assign w_rd_dat = w_err ? NOP_WORD : r_mem[w_idx];

   // ------------------------------------------------------------------
   // Program-load port
   // ------------------------------------------------------------------
   // Write one word per cycle; a fetch of the same word on this edge samples
   // the array before the update, so it sees the old contents.
   always_ff @(posedge clk) begin
      if (load_en) begin
         r_mem[load_addr] <= load_data;
      end
   end

   // ------------------------------------------------------------------
   // Read pipeline
   // ------------------------------------------------------------------
   generate
      if (OUT_REG != 0) begin : g_out_reg
         logic             r_s1_vld;
         logic [ENT_W-1:0] r_s1_dat;

         // Track the extra pipeline stage; its occupant holds a credit.
         always_ff @(posedge clk) begin
            if (reset) begin
               r_s1_vld <= 1'b0;
            end else begin
               r_s1_vld <= w_accept;
            end
         end

         // Capture the read result of the accepted fetch.
         always_ff @(posedge clk) begin
            if (w_accept) begin
               r_s1_dat <= {w_err, w_rd_dat};
            end
         end

         assign w_push     = r_s1_vld;
         assign w_push_dat = r_s1_dat;
         assign w_inflight = r_s1_vld;
      end else begin : g_no_out_reg
         // The FIFO slot itself is the synchronous read register.
         assign w_push     = w_accept;
         assign w_push_dat = {w_err, w_rd_dat};
         assign w_inflight = 1'b0;
      end
   endgenerate

   // ------------------------------------------------------------------
   // Response queue and flow control
   // ------------------------------------------------------------------
   resp_fifo2 #(
      .W (ENT_W)
   ) u_resp_fifo (
      .i_clk   (clk),
      .i_reset (reset),
      .i_push  (w_push),
      .i_dat   (w_push_dat),
      .i_pop   (w_pop),
      .o_dat   (w_head),
      .o_count (w_count),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // Accept only while a queue slot is guaranteed for every outstanding
   // fetch; this is what makes dropping a response impossible.
   assign w_credit_ok = !w_full && (({1'b0, w_count} + {2'b00, w_inflight}) < 3'd2);

   assign req_ready = !reset && w_credit_ok;
   assign w_accept  = req_valid && req_ready;

   assign rsp_valid = !reset && !w_empty;
   assign w_pop     = rsp_valid && rsp_ready;
   assign rsp_err   = w_head[DATA_W];
   assign rsp_instr = w_head[DATA_W-1:0];

endmodule
